// File: rtl/regfile_write_arbiter_pkg.sv
// Shared constants and source encodings for the register-file write arbiter.
package regfile_write_arbiter_pkg;

   // Register file geometry.
   localparam int DATA_W   = 8;
   localparam int ADDR_W   = 3;
   localparam int NUM_REGS = 1 << ADDR_W;

   // Width of the saturating stall counter.
   localparam int STALL_W  = 8;

   // Writeback source encodings, also the value driven on grant_src.
   typedef enum logic {
      SRC_ALU = 1'b0,
      SRC_MEM = 1'b1
   } src_e;

endpackage

// File: rtl/regfile_write_arbiter_wb_hold_buffer.sv
// One-entry valid/ready holding buffer for a single writeback requester.
// The entry can be popped and reloaded on the same edge, which lets a
// requester stream one write per cycle while it keeps being granted.
module wb_hold_buffer
   import regfile_write_arbiter_pkg::*;
(
   input  logic              clk,
   input  logic              rst_n,
   input  logic              valid,
   output logic              ready,
   input  logic [ADDR_W-1:0] dest,
   input  logic [DATA_W-1:0] data,
   input  logic              pop,
   output logic              load,
   output logic              full,
   output logic [ADDR_W-1:0] held_dest,
   output logic [DATA_W-1:0] held_data
);

   logic              full_reg;
   logic [ADDR_W-1:0] dest_reg;
   logic [DATA_W-1:0] data_reg;

   // Space is available when empty, or when the held entry leaves this edge.
   // ready never looks at valid, so there is no combinational loop.
   assign ready     = !full_reg || pop;
   assign load      = valid && ready;
   assign full      = full_reg;
   assign held_dest = dest_reg;
   assign held_data = data_reg;

   // Entry storage: a load wins over a pop so pop+reload keeps the buffer full.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         full_reg <= 1'b0;
         dest_reg <= '0;
         data_reg <= '0;
      end else if (load) begin
         full_reg <= 1'b1;
         dest_reg <= dest;
         data_reg <= data;
      end else if (pop) begin
         full_reg <= 1'b0;
      end
   end

endmodule

// File: rtl/regfile_write_arbiter.sv
// Shares the single register-file write port between the ALU and the
// memory-load writeback paths. Round-robin between different registers,
// oldest-first when both buffers target the same register, and a pending
// mask so decode can hold off reads of registers with writes in flight.
module regfile_write_arbiter
   import regfile_write_arbiter_pkg::*;
(
   input  logic                clk,
   input  logic                rst_n,
   input  logic                alu_valid,
   output logic                alu_ready,
   input  logic [ADDR_W-1:0]   alu_reg,
   input  logic [DATA_W-1:0]   alu_data,
   input  logic                mem_valid,
   output logic                mem_ready,
   input  logic [ADDR_W-1:0]   mem_reg,
   input  logic [DATA_W-1:0]   mem_data,
   output logic                rf_write_enable,
   output logic [ADDR_W-1:0]   rf_write_reg,
   output logic [DATA_W-1:0]   rf_write_data,
   output logic                grant_src,
   output logic [NUM_REGS-1:0] pending_mask,
   output logic [STALL_W-1:0]  stall_count
);

   logic              alu_full;
   logic              alu_load;
   logic              alu_pop;
   logic [ADDR_W-1:0] alu_dest;
   logic [DATA_W-1:0] alu_held;

   logic              mem_full;
   logic              mem_load;
   logic              mem_pop;
   logic [ADDR_W-1:0] mem_dest;
   logic [DATA_W-1:0] mem_held;

   logic               grant;
   logic               any_full;
   logic               both_full;
   logic               last_grant_reg;
   logic               age_reg;
   logic [STALL_W-1:0] stall_count_reg;

   wb_hold_buffer u_alu_buf (
      .clk       (clk),
      .rst_n     (rst_n),
      .valid     (alu_valid),
      .ready     (alu_ready),
      .dest      (alu_reg),
      .data      (alu_data),
      .pop       (alu_pop),
      .load      (alu_load),
      .full      (alu_full),
      .held_dest (alu_dest),
      .held_data (alu_held)
   );

   wb_hold_buffer u_mem_buf (
      .clk       (clk),
      .rst_n     (rst_n),
      .valid     (mem_valid),
      .ready     (mem_ready),
      .dest      (mem_reg),
      .data      (mem_data),
      .pop       (mem_pop),
      .load      (mem_load),
      .full      (mem_full),
      .held_dest (mem_dest),
      .held_data (mem_held)
   );

   assign any_full  = alu_full || mem_full;
   assign both_full = alu_full && mem_full;

   // Pick the source to write this cycle, looking only at buffer flops.
   always_comb begin
      grant = SRC_ALU;
      if (both_full) begin
         if (alu_dest == mem_dest) begin
            // Same destination: the older entry must land first.
            grant = age_reg;
         end else begin
            grant = ~last_grant_reg;
         end
      end else if (mem_full) begin
         grant = SRC_MEM;
      end
   end

   // Only the granted, full buffer is popped; the write commits on this edge.
   assign alu_pop = alu_full && (grant == SRC_ALU);
   assign mem_pop = mem_full && (grant == SRC_MEM);

   // Drive the register-file port; idle cycles present all-zero values.
   always_comb begin
      rf_write_enable = any_full;
      grant_src       = SRC_ALU;
      rf_write_reg    = '0;
      rf_write_data   = '0;
      if (any_full) begin
         grant_src     = grant;
         rf_write_reg  = (grant == SRC_MEM) ? mem_dest : alu_dest;
         rf_write_data = (grant == SRC_MEM) ? mem_held : alu_held;
      end
   end

   // Arbitration history: last granted source and which entry is older.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         last_grant_reg <= SRC_MEM;
         age_reg        <= SRC_ALU;
      end else begin
         if (any_full) begin
            last_grant_reg <= grant;
         end
         // A freshly loaded entry is younger than whatever the other buffer
         // holds; on a simultaneous load the MEM entry counts as older.
         if (alu_load) begin
            age_reg <= SRC_MEM;
         end else if (mem_load) begin
            age_reg <= SRC_ALU;
         end
      end
   end

   // Count cycles where a full buffer had to wait, saturating at all-ones.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         stall_count_reg <= '0;
      end else if (both_full && (stall_count_reg != {STALL_W{1'b1}})) begin
         stall_count_reg <= stall_count_reg + 1'b1;
      end
   end

   assign stall_count = stall_count_reg;

   // Bit r is set while either buffer holds a write to register r.
   generate
      for (genvar gi = 0; gi < NUM_REGS; gi++) begin : g_pending
         assign pending_mask[gi] = (alu_full && (alu_dest == ADDR_W'(gi))) ||
                                   (mem_full && (mem_dest == ADDR_W'(gi)));
      end
   endgenerate

endmodule

// File: tb/tb_regfile_write_arbiter.sv
// Testbench for regfile_write_arbiter: table-driven vectors plus hand-written
// multi-cycle sequences, with a queue of expected register-file writes.
module tb_regfile_write_arbiter;
   import regfile_write_arbiter_pkg::*;

   logic                clk = 1'b0;
   logic                rst_n = 1'b0;
   logic                alu_valid;
   logic                alu_ready;
   logic [ADDR_W-1:0]   alu_reg;
   logic [DATA_W-1:0]   alu_data;
   logic                mem_valid;
   logic                mem_ready;
   logic [ADDR_W-1:0]   mem_reg;
   logic [DATA_W-1:0]   mem_data;
   logic                rf_write_enable;
   logic [ADDR_W-1:0]   rf_write_reg;
   logic [DATA_W-1:0]   rf_write_data;
   logic                grant_src;
   logic [NUM_REGS-1:0] pending_mask;
   logic [7:0]          stall_count;

   always #5 clk = ~clk;

   regfile_write_arbiter dut (
      .clk             (clk),
      .rst_n           (rst_n),
      .alu_valid       (alu_valid),
      .alu_ready       (alu_ready),
      .alu_reg         (alu_reg),
      .alu_data        (alu_data),
      .mem_valid       (mem_valid),
      .mem_ready       (mem_ready),
      .mem_reg         (mem_reg),
      .mem_data        (mem_data),
      .rf_write_enable (rf_write_enable),
      .rf_write_reg    (rf_write_reg),
      .rf_write_data   (rf_write_data),
      .grant_src       (grant_src),
      .pending_mask    (pending_mask),
      .stall_count     (stall_count)
   );

   // Register file the arbiter drives; commits on the clock edge.
   logic [DATA_W-1:0] rf_model [NUM_REGS];
   always @(posedge clk) begin
      if (rf_write_enable) rf_model[rf_write_reg] <= rf_write_data;
   end

   typedef struct packed {
      logic              src;
      logic [ADDR_W-1:0] dest;
      logic [DATA_W-1:0] data;
   } wr_t;

   typedef struct {
      logic        av;
      logic [2:0]  ar;
      logic [7:0]  ad;
      logic        mv;
      logic [2:0]  mr;
      logic [7:0]  md;
      logic        first_mem;
      logic [7:0]  mask0;
      logic [7:0]  mask1;
      logic [2:0]  chk_reg;
      logic [7:0]  chk_val;
   } vec_t;

   wr_t  exp_q[$];
   vec_t vecs[7];
   int   checks = 0;
   int   errors = 0;
   int   exp_stall = 0;

   task automatic chk(input string name, input int act, input int exp);
      checks++;
      if (act != exp) begin
         errors++;
         $display("FAIL %s: got %0d (0x%0h), expected %0d (0x%0h)", name, act, act, exp, exp);
      end
   endtask

   task automatic push(input logic src, input logic [2:0] d, input logic [7:0] v);
      exp_q.push_back(wr_t'{src, d, v});
   endtask

   // Advance to the next falling edge and score any write on the port.
   task automatic cycle();
      wr_t e;
      @(negedge clk);
      if (rf_write_enable) begin
         $display("write src=%0d reg=%0d data=0x%02h", grant_src, rf_write_reg, rf_write_data);
         if (exp_q.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL unexpected_write: got src=%0d reg=%0d data=0x%02h, expected no write",
                     grant_src, rf_write_reg, rf_write_data);
         end else begin
            e = exp_q.pop_front();
            chk("write_src",  int'(grant_src),     int'(e.src));
            chk("write_reg",  int'(rf_write_reg),  int'(e.dest));
            chk("write_data", int'(rf_write_data), int'(e.data));
         end
      end
   endtask

   initial begin
      vec_t v;

      //          av ar    ad     mv mr    md     fm mask0  mask1  reg   val
      vecs[0] = '{1, 3'd0, 8'd13, 0, 3'd0, 8'd0,  0, 8'h01, 8'h00, 3'd0, 8'd13};
      vecs[1] = '{0, 3'd0, 8'd0,  1, 3'd7, 8'hA5, 1, 8'h80, 8'h00, 3'd7, 8'hA5};
      vecs[2] = '{1, 3'd1, 8'd25, 1, 3'd2, 8'd40, 0, 8'h06, 8'h04, 3'd2, 8'd40};
      vecs[3] = '{1, 3'd4, 8'd2,  1, 3'd4, 8'd1,  1, 8'h10, 8'h10, 3'd4, 8'd2};
      vecs[4] = '{1, 3'd5, 8'h11, 1, 3'd6, 8'h22, 1, 8'h60, 8'h20, 3'd5, 8'h11};
      vecs[5] = '{1, 3'd6, 8'h33, 1, 3'd6, 8'h44, 1, 8'h40, 8'h40, 3'd6, 8'h33};
      vecs[6] = '{0, 3'd0, 8'd0,  0, 3'd0, 8'd0,  0, 8'h00, 8'h00, 3'd0, 8'd13};

      // Reset with both requesters asserting valid.
      alu_valid = 1'b1; alu_reg = 3'd5; alu_data = 8'hAA;
      mem_valid = 1'b1; mem_reg = 3'd6; mem_data = 8'hBB;
      rst_n = 1'b0;
      repeat (3) @(negedge clk);
      chk("reset_we",      int'(rf_write_enable), 0);
      chk("reset_wreg",    int'(rf_write_reg),    0);
      chk("reset_wdata",   int'(rf_write_data),   0);
      chk("reset_grant",   int'(grant_src),       0);
      chk("reset_pending", int'(pending_mask),    0);
      chk("reset_aready",  int'(alu_ready),       1);
      chk("reset_mready",  int'(mem_ready),       1);
      chk("reset_stall",   int'(stall_count),     0);
      alu_valid = 1'b0;
      mem_valid = 1'b0;
      rst_n = 1'b1;
      repeat (3) cycle();
      chk("idle_after_reset_we", int'(rf_write_enable), 0);

      // Single-cycle request vectors, each drained before the next.
      for (int i = 0; i < 7; i++) begin
         v = vecs[i];
         cycle();
         alu_valid = v.av; alu_reg = v.ar; alu_data = v.ad;
         mem_valid = v.mv; mem_reg = v.mr; mem_data = v.md;
         if (v.av && v.mv) begin
            if (v.first_mem) begin
               push(SRC_MEM, v.mr, v.md);
               push(SRC_ALU, v.ar, v.ad);
            end else begin
               push(SRC_ALU, v.ar, v.ad);
               push(SRC_MEM, v.mr, v.md);
            end
         end else if (v.av) begin
            push(SRC_ALU, v.ar, v.ad);
         end else if (v.mv) begin
            push(SRC_MEM, v.mr, v.md);
         end
         cycle();
         chk("vec_mask_accept", int'(pending_mask), int'(v.mask0));
         alu_valid = 1'b0;
         mem_valid = 1'b0;
         cycle();
         chk("vec_mask_after_first", int'(pending_mask), int'(v.mask1));
         repeat (2) cycle();
         chk("vec_mask_drained", int'(pending_mask), 0);
         chk("vec_sb_drained",   exp_q.size(), 0);
         if (v.av && v.mv) exp_stall++;
         chk("vec_stall_count",  int'(stall_count), exp_stall);
         chk("vec_rf_value",     int'(rf_model[v.chk_reg]), int'(v.chk_val));
      end

      // Same register, MEM accepted one edge before ALU.
      cycle();
      mem_valid = 1'b1; mem_reg = 3'd3; mem_data = 8'd7;
      push(SRC_MEM, 3'd3, 8'd7);
      cycle();
      chk("order_mask_first", int'(pending_mask), 8'h08);
      mem_valid = 1'b0;
      alu_valid = 1'b1; alu_reg = 3'd3; alu_data = 8'd9;
      push(SRC_ALU, 3'd3, 8'd9);
      cycle();
      chk("order_mask_second", int'(pending_mask), 8'h08);
      alu_valid = 1'b0;
      repeat (2) cycle();
      chk("order_mask_drained", int'(pending_mask), 0);
      chk("order_sb_drained",   exp_q.size(), 0);
      chk("order_r3_final",     int'(rf_model[3]), 9);

      // Asynchronous reset between edges with both buffers full.
      cycle();
      alu_valid = 1'b1; alu_reg = 3'd0; alu_data = 8'hEE;
      mem_valid = 1'b1; mem_reg = 3'd7; mem_data = 8'hFF;
      @(posedge clk);
      #1;
      chk("midrst_we_before", int'(rf_write_enable), 1);
      #1;
      alu_valid = 1'b0;
      mem_valid = 1'b0;
      rst_n = 1'b0;
      #1;
      chk("midrst_we",      int'(rf_write_enable), 0);
      chk("midrst_wreg",    int'(rf_write_reg),    0);
      chk("midrst_wdata",   int'(rf_write_data),   0);
      chk("midrst_grant",   int'(grant_src),       0);
      chk("midrst_pending", int'(pending_mask),    0);
      chk("midrst_aready",  int'(alu_ready),       1);
      chk("midrst_mready",  int'(mem_ready),       1);
      chk("midrst_stall",   int'(stall_count),     0);
      @(negedge clk);
      rst_n = 1'b1;
      repeat (3) cycle();
      chk("midrst_r0_kept", int'(rf_model[0]), 13);
      chk("midrst_r7_kept", int'(rf_model[7]), 8'hA5);

      // Both sources streaming to different registers for six edges.
      cycle();
      alu_valid = 1'b1; alu_reg = 3'd1; alu_data = 8'd25;
      mem_valid = 1'b1; mem_reg = 3'd2; mem_data = 8'd40;
      for (int k = 0; k < 7; k++) begin
         if (k % 2 == 0) push(SRC_ALU, 3'd1, 8'd25);
         else            push(SRC_MEM, 3'd2, 8'd40);
      end
      for (int j = 1; j <= 6; j++) begin
         cycle();
         chk("rr_stall_step", int'(stall_count), j - 1);
         if (j == 6) begin
            alu_valid = 1'b0;
            mem_valid = 1'b0;
         end
      end
      repeat (3) cycle();
      chk("rr_stall_final",  int'(stall_count), 6);
      chk("rr_sb_drained",   exp_q.size(), 0);
      chk("rr_mask_drained", int'(pending_mask), 0);
      chk("rr_r1",           int'(rf_model[1]), 25);
      chk("rr_r2",           int'(rf_model[2]), 40);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
